mmio_led_responder: RTL and testbench

//  Memory-mapped I/O responder that terminates the CPU's single-port load/store bus for the board LEDs.
//  The CPU is the initiator; this block decodes word-aligned register offsets, performs writes, and returns read data with a one-cycle handshake.
//  It drives the 16-bit LED output, including a hardware blink overlay.
//  It also exposes a synchronised switch input and a free-running cycle counter for software timing.

---
 rtl/mmio_led_responder.sv | 177 +++++++++++++++++
 tb/tb_mmio_led_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_led_responder.sv
// mmio_led_responder
//   Terminates the CPU load/store bus for the board LEDs. One request is
//   accepted from IDLE, and a single-cycle ack carrying err/rdata follows on
//   the next cycle. A new request can be accepted every second cycle.
//   Register words (addr[4:2]): LED_DATA, LED_SET, LED_CLR, LED_TGL, SW,
//   CYCLES, BLK_MASK, BLK_PER.
// Ports
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   req/we     : request strobe and write select (sampled in IDLE only)
//   addr       : byte offset; addr[1:0] ignored, bits above [4] must be 0
//   wdata      : write data
//   sw         : asynchronous switch inputs (two-flop synchronised)
//   ack/err    : response strobe and error flag
//   rdata      : read data, valid with ack, otherwise 0
//   LED        : LED drive, LED_DATA with the blink overlay applied
module mmio_led_responder #(
  parameter int unsigned      LED_W     = 16,
  parameter int unsigned      DATA_W    = 32,
  parameter logic [LED_W-1:0] RESET_LED = {LED_W{1'b0}},
  parameter int unsigned      ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LED_W-1:0]  sw,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [LED_W-1:0]  LED
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  localparam logic [2:0] W_LED_DATA = 3'd0;
  localparam logic [2:0] W_LED_SET  = 3'd1;
  localparam logic [2:0] W_LED_CLR  = 3'd2;
  localparam logic [2:0] W_LED_TGL  = 3'd3;
  localparam logic [2:0] W_SW       = 3'd4;
  localparam logic [2:0] W_CYCLES   = 3'd5;
  localparam logic [2:0] W_BLK_MASK = 3'd6;
  localparam logic [2:0] W_BLK_PER  = 3'd7;

  state_t             state_q, state_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [LED_W-1:0]   led_data_q, led_data_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [LED_W-1:0]   blk_mask_q, blk_mask_d;
  logic [31:0]        blk_per_q, blk_per_d;
  logic [31:0]        bcnt_q, bcnt_d;
  logic               phase_q, phase_d;
  logic [31:0]        cycles_q, cycles_d;
  logic [LED_W-1:0]   sw_meta_q, sw_meta_d;
  logic [LED_W-1:0]   sw_sync_q, sw_sync_d;

  logic [2:0]         word;
  logic               addr_hi_nz;
  logic               acc_err;
  logic               accept;
  logic               do_write;
  logic               blk_restart;
  logic [LED_W-1:0]   wr_led;
  logic [DATA_W-1:0]  rd_val;

  // Offsets beyond the 8-word map only exist when the bus is wider than 5 bits.
  generate
    if (ADDR_W > 5) begin : g_addr_hi
      assign addr_hi_nz = |addr[ADDR_W-1:5];
    end else begin : g_no_addr_hi
      assign addr_hi_nz = 1'b0;
    end
  endgenerate

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  always_comb begin
    word     = addr[4:2];
    acc_err  = addr_hi_nz | (we & ((word == W_SW) | (word == W_CYCLES)));
    accept   = (state_q == S_IDLE) & req;
    do_write = accept & we & ~acc_err;
    wr_led   = wdata[LED_W-1:0];

    // Read value is taken from the registers before this edge's update.
    case (word)
      W_SW:       rd_val = DATA_W'(sw_sync_q);
      W_CYCLES:   rd_val = DATA_W'(cycles_q);
      W_BLK_MASK: rd_val = DATA_W'(blk_mask_q);
      W_BLK_PER:  rd_val = DATA_W'(blk_per_q);
      default:    rd_val = DATA_W'(led_data_q);
    endcase

    led_data_d  = led_data_q;
    blk_mask_d  = blk_mask_q;
    blk_per_d   = blk_per_q;
    blk_restart = 1'b0;
    if (do_write) begin
      case (word)
        W_LED_DATA: led_data_d = wr_led;
        W_LED_SET:  led_data_d = led_data_q | wr_led;
        W_LED_CLR:  led_data_d = led_data_q & ~wr_led;
        W_LED_TGL:  led_data_d = led_data_q ^ wr_led;
        W_BLK_MASK: blk_mask_d = wr_led;
        W_BLK_PER: begin
          blk_per_d   = wdata[31:0];
          blk_restart = 1'b1;
        end
        default: ;
      endcase
    end

    // Blink: each phase lasts BLK_PER cycles; a zero period parks phase at 0.
    bcnt_d  = bcnt_q + 32'd1;
    phase_d = phase_q;
    if (blk_restart || blk_per_q == 32'd0) begin
      bcnt_d  = 32'd0;
      phase_d = 1'b0;
    end else if (bcnt_q == blk_per_q - 32'd1) begin
      bcnt_d  = 32'd0;
      phase_d = ~phase_q;
    end

    led_d     = led_data_q ^ (blk_mask_q & {LED_W{phase_q}});
    cycles_d  = cycles_q + 32'd1;
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;

    // Erroring accesses (including writes to read-only words) return rdata=0.
    ack_d   = accept;
    err_d   = accept & acc_err;
    rdata_d = (accept && !acc_err) ? rd_val : {DATA_W{1'b0}};
    state_d = accept ? S_RESP : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= {DATA_W{1'b0}};
      led_data_q <= RESET_LED;
      led_q      <= RESET_LED;
      blk_mask_q <= {LED_W{1'b0}};
      blk_per_q  <= 32'd0;
      bcnt_q     <= 32'd0;
      phase_q    <= 1'b0;
      cycles_q   <= 32'd0;
      sw_meta_q  <= {LED_W{1'b0}};
      sw_sync_q  <= {LED_W{1'b0}};
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      led_data_q <= led_data_d;
      led_q      <= led_d;
      blk_mask_q <= blk_mask_d;
      blk_per_q  <= blk_per_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      cycles_q   <= cycles_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
    end
  end

  // A reset raised during the response cycle suppresses the pending ack.
  assign ack   = ack_q & ~rst;
  assign err   = err_q & ~rst;
  assign rdata = rst ? {DATA_W{1'b0}} : rdata_q;
  assign LED   = led_q;

endmodule

// File: tb/tb_mmio_led_responder.sv
module tb_mmio_led_responder;

  localparam logic [15:0] RST_LED = 16'h00A5;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [15:0] sw;
  logic        ack, err;
  logic [31:0] rdata;
  logic [15:0] led;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mmio_led_responder #(
    .LED_W(16), .DATA_W(32), .RESET_LED(RST_LED), .ADDR_W(6)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .sw(sw), .ack(ack), .err(err), .rdata(rdata), .LED(led)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (edge-indexed, arithmetic) ----------------
  int unsigned edge_i = 0;
  int unsigned rst_edge = 0;
  int unsigned m_blk_start = 0;
  logic [15:0] m_led_data, m_mask, m_led;
  logic [31:0] m_per;
  logic [15:0] sw_at [int unsigned];
  bit          m_busy = 0;
  bit          model_ok = 0;
  logic        m_ack, m_err;
  logic [31:0] m_rdata;

  // Blink phase after edge 'at': number of whole periods since restart, mod 2.
  function automatic logic m_phase(input int unsigned at);
    if (m_per == 32'd0) return 1'b0;
    return ((longint'(at - m_blk_start) / longint'(m_per)) % 2) == 1;
  endfunction

  always @(posedge clk) begin
    logic [15:0] new_led;
    logic [2:0]  wd;
    logic        bad;
    logic [31:0] rv;
    edge_i++;
    sw_at[edge_i] = sw;
    if (rst) begin
      rst_edge    = edge_i;
      m_blk_start = edge_i;
      m_led_data  = RST_LED;
      m_led       = RST_LED;
      m_mask      = 16'h0;
      m_per       = 32'h0;
      m_busy      = 0;
      m_ack       = 0;
      m_err       = 0;
      m_rdata     = 32'h0;
      model_ok    = 1;
    end else begin
      new_led = m_led_data ^ (m_mask & {16{m_phase(edge_i - 1)}});
      m_ack = 0; m_err = 0; m_rdata = 32'h0;
      if (!m_busy && req) begin
        wd  = addr[4:2];
        bad = addr[5] || (we && (wd == 3'd4 || wd == 3'd5));
        case (wd)
          3'd4:    rv = (edge_i - 2 > rst_edge && edge_i >= 2) ? {16'h0, sw_at[edge_i - 2]} : 32'h0;
          3'd5:    rv = edge_i - rst_edge - 1;
          3'd6:    rv = {16'h0, m_mask};
          3'd7:    rv = m_per;
          default: rv = {16'h0, m_led_data};
        endcase
        m_ack   = 1;
        m_err   = bad;
        m_rdata = bad ? 32'h0 : rv;
        if (we && !bad) begin
          case (wd)
            3'd0: m_led_data = wdata[15:0];
            3'd1: m_led_data = m_led_data | wdata[15:0];
            3'd2: m_led_data = m_led_data & ~wdata[15:0];
            3'd3: m_led_data = m_led_data ^ wdata[15:0];
            3'd6: m_mask = wdata[15:0];
            3'd7: begin m_per = wdata; m_blk_start = edge_i; end
            default: ;
          endcase
        end
        m_busy = 1;
      end else begin
        m_busy = 0;
      end
      m_led = new_led;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check_val("ack",   {31'h0, ack},  {31'h0, m_ack & ~rst});
      check_val("err",   {31'h0, err},  {31'h0, m_err & ~rst});
      check_val("rdata", rdata,         rst ? 32'h0 : m_rdata);
      check_val("led",   {16'h0, led},  {16'h0, m_led});
    end
  end

  // ---------------- stimulus ----------------
  logic        last_ack, last_err;
  logic [31:0] last_rdata;

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic txn(input logic w, input logic [5:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    last_ack = ack; last_err = err; last_rdata = rdata;
    @(posedge clk); #1;
    $display("txn %s addr=%02h wdata=%08h ack=%0b err=%0b rdata=%08h",
             w ? "WR" : "RD", a, d, last_ack, last_err, last_rdata);
  endtask

  task automatic burst(input int n);
    req = 1'b1; we = 1'b0;
    for (int i = 0; i < n; i++) begin
      addr = 6'($urandom_range(0, 31));
      @(posedge clk); #1;
    end
    req = 1'b0;
    @(posedge clk); #1;
    $display("burst of %0d cycles with req held", n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c1, c2;
    logic [31:0] brd [0:7];
    logic [15:0] led_snap;
    int acks;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sw = '0;

    // 1. reset
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_val("rst_led", {16'h0, led}, {16'h0, RST_LED});
    check_val("rst_ack", {31'h0, ack}, 32'h0);
    txn(1'b0, 6'h14, 32'h0); c1 = last_rdata;
    txn(1'b0, 6'h14, 32'h0); c2 = last_rdata;
    check_val("cycles_step", c2 - c1, 32'd2);

    // 2. LED_DATA write and set/clear/toggle
    txn(1'b1, 6'h00, 32'h0000_1234); check_val("wr_ack", {31'h0, last_ack}, 32'h1);
    txn(1'b1, 6'h04, 32'h0000_00F0); check_val("set_ack", {31'h0, last_ack}, 32'h1);
    txn(1'b1, 6'h08, 32'h0000_0004); check_val("clr_ack", {31'h0, last_ack}, 32'h1);
    txn(1'b1, 6'h0C, 32'h0000_8001); check_val("tgl_ack", {31'h0, last_ack}, 32'h1);
    txn(1'b0, 6'h00, 32'h0);
    check_val("led_data_rd", last_rdata, 32'h0000_92F1);
    check_val("led_out", {16'h0, led}, 32'h0000_92F1);

    // 3. req held continuously, sw change mid-burst
    sw = 16'h0000; idle(3);
    req = 1'b1; we = 1'b0; addr = 6'h10; acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 2) sw = 16'hFFFF;
      @(negedge clk);
      if (ack) begin brd[acks] = rdata; acks++; end
    end
    req = 1'b0;
    @(posedge clk); #1;
    check_val("burst_acks", 32'(acks), 32'd5);
    check_val("sw_before", brd[1], 32'h0);
    check_val("sw_after", brd[3], 32'h0000_FFFF);

    // 4. blink
    txn(1'b1, 6'h18, 32'h0000_000F);
    txn(1'b1, 6'h00, 32'h0);
    txn(1'b1, 6'h1C, 32'd3);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      check_val("blink", {16'h0, led}, (((j - 1) / 3) % 2 == 1) ? 32'hF : 32'h0);
    end
    @(posedge clk); #1;
    txn(1'b1, 6'h1C, 32'd0);
    for (int j = 0; j < 3; j++) begin
      check_val("blink_off", {16'h0, led}, 32'h0);
      idle(1);
    end

    // 5. unmapped and read-only writes
    txn(1'b1, 6'h00, 32'h0000_3C3C);
    idle(1);
    led_snap = led;
    txn(1'b0, 6'h14, 32'h0); c1 = last_rdata;
    txn(1'b0, 6'h20, 32'h0);
    check_val("err_20", {31'h0, last_err}, 32'h1); check_val("rd_20", last_rdata, 32'h0);
    txn(1'b0, 6'h3C, 32'h0);
    check_val("err_3c", {31'h0, last_err}, 32'h1); check_val("rd_3c", last_rdata, 32'h0);
    txn(1'b1, 6'h14, 32'hFFFF_FFFF);
    check_val("err_wr14", {31'h0, last_err}, 32'h1);
    txn(1'b0, 6'h14, 32'h0); c2 = last_rdata;
    check_val("cycles_unaff", c2 - c1, 32'd8);
    check_val("led_unaff", {16'h0, led}, {16'h0, led_snap});

    // 6. reset during response cycle of a write
    txn(1'b1, 6'h18, 32'h0000_00FF);
    req = 1'b1; we = 1'b1; addr = 6'h00; wdata = 32'h0000_5A5A;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_val("rst_abort_ack", {31'h0, ack}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rst2_led", {16'h0, led}, {16'h0, RST_LED});
    txn(1'b0, 6'h00, 32'h0); check_val("rst2_data", last_rdata, {16'h0, RST_LED});
    txn(1'b0, 6'h18, 32'h0); check_val("rst2_mask", last_rdata, 32'h0);
    txn(1'b0, 6'h1C, 32'h0); check_val("rst2_per", last_rdata, 32'h0);

    // randomized traffic, checked cycle by cycle against the model
    for (int k = 0; k < 400; k++) begin
      int r;
      logic [5:0] a;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
      if (r < 3) begin
        rst = 1'b1; req = 1'($urandom); we = 1'b1; addr = 6'h00; wdata = $urandom;
        idle($urandom_range(1, 2));
        rst = 1'b0; req = 1'b0; we = 1'b0;
        $display("reset pulse");
      end else if (r < 10) begin
        burst($urandom_range(2, 9));
      end else begin
        a = 6'($urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) a[5] = 1'b1;
        d = $urandom;
        if (a[4:2] == 3'd7) d = 32'($urandom_range(0, 6));
        txn(1'($urandom), a, d);
      end
      idle($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
